// File: rtl/ctrl_seq_pkg.sv
// Shared opcodes, register codes and state encoding for control_sequencer.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (adds the HALT state).
package ctrl_seq_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_MV   = 4'h2;
  localparam logic [3:0] OP_ADDI = 4'h3;

  localparam logic [1:0] REG_A   = 2'd0;
  localparam logic [1:0] REG_B   = 2'd1;
  localparam logic [1:0] REG_Z   = 2'd2;
  localparam logic [1:0] REG_RSV = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
`ifdef CTRL_ILLEGAL_TRAP_EN
    S_T2   = 2'd2,
    S_HALT = 2'd3
`else
    S_T2   = 2'd2
`endif
  } state_t;

  // One-hot strobe vector {Z, B, A}; the reserved code selects nothing.
  function automatic logic [2:0] reg_onehot(input logic [1:0] code);
    logic [2:0] oh;
    oh = '0;
    case (code)
      REG_A:   oh = 3'b001;
      REG_B:   oh = 3'b010;
      REG_Z:   oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder for control_sequencer.
// Illegal words decode to no strobes so the top can treat them as NOP or trap.
module ctrl_decode
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned IMM_W   = 8,
  localparam int unsigned INSTR_W = 8 + IMM_W
) (
  input  logic [INSTR_W-1:0] ir,
  output logic [3:0]         opcode,
  output logic [IMM_W-1:0]   imm,
  output logic [2:0]         src_oh,
  output logic [2:0]         dst_oh,
  output logic               uses_imm,
  output logic               two_step,
  output logic               is_illegal
);

  logic [1:0] dst;
  logic [1:0] src;

  assign opcode = ir[INSTR_W-1 -: 4];
  assign dst    = ir[IMM_W+3 -: 2];
  assign src    = ir[IMM_W+1 -: 2];
  assign imm    = ir[IMM_W-1:0];

  always_comb begin
    src_oh     = '0;
    dst_oh     = '0;
    uses_imm   = 1'b0;
    two_step   = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_NOP: begin
      end
      OP_LDI: begin
        dst_oh   = reg_onehot(REG_A);
        uses_imm = 1'b1;
      end
      OP_MV: begin
        is_illegal = (dst == REG_RSV) || (src == REG_RSV);
        src_oh     = reg_onehot(src);
        dst_oh     = reg_onehot(dst);
      end
      OP_ADDI: begin
        is_illegal = (dst == REG_RSV) || (src == REG_RSV);
        src_oh     = reg_onehot(src);
        dst_oh     = reg_onehot(dst);
        uses_imm   = 1'b1;
        two_step   = (dst != REG_Z);
      end
      default: is_illegal = 1'b1;
    endcase
    if (is_illegal) begin
      src_oh   = '0;
      dst_oh   = '0;
      uses_imm = 1'b0;
      two_step = 1'b0;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Instruction sequencer driving A/B/Z datapath strobes and immediates through T1..T2.
// Build option: define CTRL_ILLEGAL_TRAP_EN to halt on illegal instructions.
module control_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IMM_W   = 8,
  localparam int unsigned INSTR_W = 8 + IMM_W
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic               RAin,
  output logic               RBin,
  output logic               RZin,
  output logic               RAout,
  output logic               RBout,
  output logic               RZout,
  output logic [DATA_W-1:0]  AddImmediate,
  output logic [DATA_W-1:0]  RegisterAImmediate,
  output logic               done,
  output logic               illegal
);

  state_t               state_q, state_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [2:0]           in_q, in_d;
  logic [2:0]           out_q, out_d;
  logic [DATA_W-1:0]    add_imm_q, add_imm_d;
  logic [DATA_W-1:0]    lda_imm_q, lda_imm_d;
  logic                 done_q, done_d;
  logic                 illegal_q, illegal_d;
  logic                 ready_q, ready_d;

  logic [3:0]           dec_op;
  logic [IMM_W-1:0]     dec_imm;
  logic [2:0]           dec_src;
  logic [2:0]           dec_dst;
  logic                 dec_uses_imm;
  logic                 dec_two_step;
  logic                 dec_illegal;
  logic [DATA_W-1:0]    imm_ext;

  // Outputs are registered, so the decoder looks at the IR value the next state will hold.
  ctrl_decode #(
    .IMM_W (IMM_W)
  ) u_decode (
    .ir         (ir_d),
    .opcode     (dec_op),
    .imm        (dec_imm),
    .src_oh     (dec_src),
    .dst_oh     (dec_dst),
    .uses_imm   (dec_uses_imm),
    .two_step   (dec_two_step),
    .is_illegal (dec_illegal)
  );

  assign imm_ext = dec_uses_imm ? DATA_W'(dec_imm) : '0;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_T1;
        end
      end
      S_T1: begin
        if (dec_illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_IDLE;
`endif
        end else if (dec_two_step) begin
          state_d = S_T2;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_T2: state_d = S_IDLE;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_d      = '0;
    out_d     = '0;
    add_imm_d = '0;
    lda_imm_d = '0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    ready_d   = 1'b0;
    case (state_d)
      S_IDLE: ready_d = 1'b1;
      S_T1: begin
        if (dec_illegal) begin
          illegal_d = 1'b1;
`ifndef CTRL_ILLEGAL_TRAP_EN
          done_d    = 1'b1;
`endif
        end else begin
          case (dec_op)
            OP_NOP: done_d = 1'b1;
            OP_LDI: begin
              in_d      = dec_dst;
              lda_imm_d = imm_ext;
              done_d    = 1'b1;
            end
            OP_MV: begin
              in_d   = dec_dst;
              out_d  = dec_src;
              done_d = 1'b1;
            end
            OP_ADDI: begin
              out_d     = dec_src;
              in_d      = reg_onehot(REG_Z);
              add_imm_d = imm_ext;
              done_d    = !dec_two_step;
            end
            default: begin
            end
          endcase
        end
      end
      S_T2: begin
        out_d  = reg_onehot(REG_Z);
        in_d   = dec_dst;
        done_d = 1'b1;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_HALT: illegal_d = 1'b1;
`endif
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      in_q      <= '0;
      out_q     <= '0;
      add_imm_q <= '0;
      lda_imm_q <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      in_q      <= in_d;
      out_q     <= out_d;
      add_imm_q <= add_imm_d;
      lda_imm_q <= lda_imm_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      ready_q   <= ready_d;
    end
  end

  assign instr_ready        = ready_q;
  assign RAin               = in_q[0];
  assign RBin               = in_q[1];
  assign RZin               = in_q[2];
  assign RAout              = out_q[0];
  assign RBout              = out_q[1];
  assign RZout              = out_q[2];
  assign AddImmediate       = add_imm_q;
  assign RegisterAImmediate = lda_imm_q;
  assign done               = done_q;
  assign illegal            = illegal_q;

endmodule
